// File: rtl/des_pkg.sv
// des_pkg: DES S-box tables, P permutation, FSM state type and width constants
package des_pkg;

    localparam int IN_W    = 48;
    localparam int OUT_W   = 32;
    localparam int CHUNK_W = 6;
    localparam int NIB_W   = 4;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    // SBOX[box][{row,col}]: index 0 of each 64-entry table is the leftmost hex digit
    localparam logic [0:7][0:63][NIB_W-1:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // DES P permutation, 1-based DES bit numbers (bit 1 = MSB)
    localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                  2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    // output DES bit i+1 takes input DES bit P_TAB[i]
    function automatic logic [OUT_W-1:0] pperm(input logic [OUT_W-1:0] a);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_W; i++) r[OUT_W-1-i] = a[OUT_W-P_TAB[i]];
        return r;
    endfunction

endpackage

// File: rtl/sbox_compress_if.sv
// sbox_compress_if: valid/ready input (48-bit) and output (32-bit) channels of the S-box stage
interface sbox_compress_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [des_pkg::IN_W-1:0]    in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [des_pkg::OUT_W-1:0]   out_data;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);

endinterface

// File: rtl/sbox_lookup.sv
// sbox_lookup: combinational single S-box lookup shared across all eight boxes
module sbox_lookup
    import des_pkg::*;
(
    input  logic [2:0]         box_i,
    input  logic [CHUNK_W-1:0] chunk_i,
    output logic [NIB_W-1:0]   val_o
);

    // row = outer bits {c5,c0}, column = inner bits c4..c1
    assign val_o = SBOX[box_i][{chunk_i[5], chunk_i[0], chunk_i[4:1]}];

endmodule

// File: rtl/sbox_compress.sv
// sbox_compress: serial DES S-box compression 48->32 bits, one box per cycle; SBOX_PPERM_EN adds the P permutation
module sbox_compress
    import des_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    sbox_compress_if.slave  bus
);

    state_t             state_q;
    logic [2:0]         idx_q;
    logic [IN_W-1:0]    shreg_q;
    logic [OUT_W-1:0]   acc_q;
    logic [OUT_W-1:0]   res_q;
    logic [NIB_W-1:0]   nib_d;
    logic [OUT_W-1:0]   acc_d;
    logic [OUT_W-1:0]   res_d;

    sbox_lookup u_lookup (
        .box_i   (idx_q),
        .chunk_i (shreg_q[IN_W-1 -: CHUNK_W]),
        .val_o   (nib_d)
    );

    assign acc_d = {acc_q[OUT_W-NIB_W-1:0], nib_d};

`ifdef SBOX_PPERM_EN
    assign res_d = pperm(acc_d);
`else
    assign res_d = acc_d;
`endif

    // control FSM: capture in IDLE, substitute one chunk per cycle in SUB, hold result in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    shreg_q <= bus.in_data;
                    idx_q   <= '0;
                    acc_q   <= '0;
                    state_q <= SUB;
                end
                SUB: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q << CHUNK_W;
                    idx_q   <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        res_q   <= res_d;
                        state_q <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;

endmodule
